sfx_arbiter: RTL and testbench

- Shares the single tone PWM generator between background music and one-shot game sound effects: drop, line clear and game over.
- Sits between the music ROM's `tone` output and the tone `PWM_gen`.
- Plays prioritised fixed tone sequences and freezes the beat player while an effect sounds.
- Silences output after game over until the mode changes.

---
 rtl/sfx_pkg.sv | 52 +++++
 rtl/sfx_arbiter_if.sv | 27 ++
 rtl/sfx_rom.sv | 51 +++++
 rtl/sfx_arbiter.sv | 143 ++++++++++++++
 tb/tb_sfx_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfx_pkg
// Brief    : Shared types, effect IDs, lengths and tone constants for the
//            sound-effect arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sfx_pkg;

    typedef enum logic [1:0] {
        S_MUSIC  = 2'd0,
        S_SFX    = 2'd1,
        S_SILENT = 2'd2
    } state_t;

    // Numeric order doubles as priority: over > clear > drop > none.
    typedef enum logic [1:0] {
        FX_NONE  = 2'd0,
        FX_DROP  = 2'd1,
        FX_CLEAR = 2'd2,
        FX_OVER  = 2'd3
    } fx_t;

    localparam int LEN_DROP  = 2;
    localparam int LEN_CLEAR = 4;
    localparam int LEN_OVER  = 8;

    localparam logic [31:0] TONE_G3  = 32'd196;
    localparam logic [31:0] TONE_C4  = 32'd262;
    localparam logic [31:0] TONE_CS4 = 32'd277;
    localparam logic [31:0] TONE_D4  = 32'd294;
    localparam logic [31:0] TONE_DS4 = 32'd311;
    localparam logic [31:0] TONE_E4  = 32'd330;
    localparam logic [31:0] TONE_F4  = 32'd349;
    localparam logic [31:0] TONE_FS4 = 32'd370;
    localparam logic [31:0] TONE_G4  = 32'd392;
    localparam logic [31:0] TONE_C5  = 32'd523;
    localparam logic [31:0] TONE_E5  = 32'd659;
    localparam logic [31:0] TONE_G5  = 32'd784;
    localparam logic [31:0] TONE_C6  = 32'd1047;

    function automatic logic [2:0] fx_last_step(input fx_t fx);
        case (fx)
            FX_DROP:  fx_last_step = 3'(LEN_DROP - 1);
            FX_CLEAR: fx_last_step = 3'(LEN_CLEAR - 1);
            FX_OVER:  fx_last_step = 3'(LEN_OVER - 1);
            default:  fx_last_step = 3'd0;
        endcase
    endfunction

endpackage : sfx_pkg
`default_nettype wire

// File: rtl/sfx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sfx_arbiter_if
// Brief    : Music/effect request and tone output bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sfx_arbiter_if;
    logic [1:0]  mode;
    logic [31:0] music_tone;
    logic        req_drop;
    logic        req_clear;
    logic        req_over;
    logic [31:0] tone_out;
    logic        music_hold;
    logic        sfx_busy;

    modport master (
        output mode, music_tone, req_drop, req_clear, req_over,
        input  tone_out, music_hold, sfx_busy
    );

    modport slave (
        input  mode, music_tone, req_drop, req_clear, req_over,
        output tone_out, music_hold, sfx_busy
    );
endinterface : sfx_arbiter_if
`default_nettype wire

// File: rtl/sfx_rom.sv
`default_nettype none
// ============================================================================
// Module   : sfx_rom
// Brief    : Combinational effect tone table; out-of-range steps give 0 Hz.
// Revision : 1.0 - initial release
// ============================================================================
module sfx_rom
    import sfx_pkg::*;
(
    input  fx_t         fx,
    input  logic [2:0]  step,
    output logic [31:0] tone
);

    always_comb begin
        tone = '0;
        case (fx)
            FX_DROP: begin
                case (step)
                    3'd0:    tone = TONE_C4;
                    3'd1:    tone = TONE_G3;
                    default: tone = '0;
                endcase
            end
            FX_CLEAR: begin
                case (step)
                    3'd0:    tone = TONE_C5;
                    3'd1:    tone = TONE_E5;
                    3'd2:    tone = TONE_G5;
                    3'd3:    tone = TONE_C6;
                    default: tone = '0;
                endcase
            end
            FX_OVER: begin
                case (step)
                    3'd0:    tone = TONE_G4;
                    3'd1:    tone = TONE_FS4;
                    3'd2:    tone = TONE_F4;
                    3'd3:    tone = TONE_E4;
                    3'd4:    tone = TONE_DS4;
                    3'd5:    tone = TONE_D4;
                    3'd6:    tone = TONE_CS4;
                    default: tone = TONE_C4;
                endcase
            end
            default: tone = '0;
        endcase
    end

endmodule : sfx_rom
`default_nettype wire

// File: rtl/sfx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sfx_arbiter
// Brief    : Shares the tone PWM between background music and prioritised
//            one-shot effects; freezes the beat player while an effect sounds.
// Revision : 1.0 - initial release
// ============================================================================
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int TICK_DIV = 6_250_000
) (
    input  logic          clk,
    input  logic          reset,
    sfx_arbiter_if.slave  bus
);

    localparam logic [31:0] c_tick_last = 32'(TICK_DIV - 1);

    state_t      r_state;
    state_t      w_nxt_state;
    fx_t         r_fx;
    fx_t         w_nxt_fx;
    fx_t         w_req_fx;
    logic [2:0]  r_step;
    logic [2:0]  w_nxt_step;
    logic [31:0] r_tick;
    logic [31:0] w_nxt_tick;
    logic [1:0]  r_mode;
    logic [31:0] r_tone_out;
    logic [31:0] w_nxt_tone;
    logic [31:0] w_rom_tone;
    logic        r_music_hold;
    logic        r_sfx_busy;
    logic        w_mode_ok;
    logic        w_mode_chg;

    assign w_mode_ok  = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    assign w_mode_chg = (bus.mode != r_mode);

    always_comb begin
        w_req_fx = FX_NONE;
        if (w_mode_ok) begin
            if (bus.req_over)       w_req_fx = FX_OVER;
            else if (bus.req_clear) w_req_fx = FX_CLEAR;
            else if (bus.req_drop)  w_req_fx = FX_DROP;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_fx    = r_fx;
        w_nxt_step  = r_step;
        w_nxt_tick  = r_tick;
        case (r_state)
            S_MUSIC: begin
                if (w_req_fx != FX_NONE) begin
                    w_nxt_state = S_SFX;
                    w_nxt_fx    = w_req_fx;
                    w_nxt_step  = 3'd0;
                    w_nxt_tick  = '0;
                end
            end
            S_SFX: begin
                if (w_mode_chg) begin
                    w_nxt_state = S_MUSIC;
                    w_nxt_fx    = FX_NONE;
                    w_nxt_step  = 3'd0;
                    w_nxt_tick  = '0;
                end else if ((w_req_fx != FX_NONE) && (w_req_fx >= r_fx)) begin
                    // Equal priority restarts, higher priority preempts.
                    w_nxt_fx   = w_req_fx;
                    w_nxt_step = 3'd0;
                    w_nxt_tick = '0;
                end else if (r_tick == c_tick_last) begin
                    w_nxt_tick = '0;
                    if (r_step == fx_last_step(r_fx)) begin
                        w_nxt_state = (r_fx == FX_OVER) ? S_SILENT : S_MUSIC;
                        w_nxt_fx    = FX_NONE;
                        w_nxt_step  = 3'd0;
                    end else begin
                        w_nxt_step = r_step + 3'd1;
                    end
                end else begin
                    w_nxt_tick = r_tick + 32'd1;
                end
            end
            S_SILENT: begin
                if (w_mode_chg) begin
                    w_nxt_state = S_MUSIC;
                end
            end
            default: begin
                w_nxt_state = S_MUSIC;
                w_nxt_fx    = FX_NONE;
                w_nxt_step  = 3'd0;
                w_nxt_tick  = '0;
            end
        endcase
    end

    sfx_rom u_rom (
        .fx   (w_nxt_fx),
        .step (w_nxt_step),
        .tone (w_rom_tone)
    );

    // Outputs are loaded from the next state so they change on the same edge.
    always_comb begin
        case (w_nxt_state)
            S_MUSIC: w_nxt_tone = bus.music_tone;
            S_SFX:   w_nxt_tone = w_rom_tone;
            default: w_nxt_tone = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        r_mode <= bus.mode;
        if (reset) begin
            r_state      <= S_MUSIC;
            r_fx         <= FX_NONE;
            r_step       <= 3'd0;
            r_tick       <= '0;
            r_tone_out   <= '0;
            r_music_hold <= 1'b0;
            r_sfx_busy   <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_fx         <= w_nxt_fx;
            r_step       <= w_nxt_step;
            r_tick       <= w_nxt_tick;
            r_tone_out   <= w_nxt_tone;
            r_music_hold <= (w_nxt_state != S_MUSIC);
            r_sfx_busy   <= (w_nxt_state == S_SFX);
        end
    end

    assign bus.tone_out   = r_tone_out;
    assign bus.music_hold = r_music_hold;
    assign bus.sfx_busy   = r_sfx_busy;

endmodule : sfx_arbiter
`default_nettype wire

// File: tb/tb_sfx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_arbiter
// Brief    : Directed scenarios plus random traffic against an elapsed-time
//            reference model of the sound-effect arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfx_arbiter;

    localparam int TD = 4;

    logic clk;
    logic reset;
    sfx_arbiter_if bus ();

    sfx_arbiter #(.TICK_DIV(TD)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int seq [4][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{262, 196, 0, 0, 0, 0, 0, 0},
        '{523, 659, 784, 1047, 0, 0, 0, 0},
        '{392, 370, 349, 330, 311, 294, 277, 262}
    };
    int fx_len [4] = '{0, 2, 4, 8};

    // Model: 0 music, 1 effect, 2 silent; elapsed cycles since effect start.
    int          m_st;
    int          m_fx;
    int          m_el;
    logic [1:0]  m_prev;
    logic [31:0] e_tone;
    logic        e_hold;
    logic        e_busy;

    int          n_pass;
    int          n_total;
    logic [1:0]  cur_mode;
    logic [31:0] cur_tone;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step(input logic rs, input logic [1:0] md, input logic [31:0] mt,
                              input logic rd, input logic rc, input logic ro);
        int req;
        bit chg;
        req = 0;
        if (md == 2'd1 || md == 2'd2) req = ro ? 3 : rc ? 2 : rd ? 1 : 0;
        chg = (md != m_prev);
        if (rs) begin
            m_st = 0; m_fx = 0; m_el = 0;
            e_tone = 0; e_hold = 0; e_busy = 0;
        end else begin
            case (m_st)
                0: if (req != 0) begin m_st = 1; m_fx = req; m_el = 0; end
                1: begin
                    if (chg) m_st = 0;
                    else if (req != 0 && req >= m_fx) begin m_fx = req; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el == fx_len[m_fx] * TD) m_st = (m_fx == 3) ? 2 : 0;
                    end
                end
                default: if (chg) m_st = 0;
            endcase
            e_tone = (m_st == 0) ? mt : (m_st == 1) ? 32'(seq[m_fx][m_el / TD]) : 32'd0;
            e_hold = (m_st != 0);
            e_busy = (m_st == 1);
        end
        m_prev = md;
    endtask

    task automatic cycle(input logic rs, input logic rd, input logic rc, input logic ro);
        @(negedge clk);
        reset          = rs;
        bus.mode       = cur_mode;
        bus.music_tone = cur_tone;
        bus.req_drop   = rd;
        bus.req_clear  = rc;
        bus.req_over   = ro;
        @(posedge clk);
        model_step(rs, cur_mode, cur_tone, rd, rc, ro);
        #1;
        check("tone_out", bus.tone_out, e_tone);
        check("music_hold", {31'd0, bus.music_hold}, {31'd0, e_hold});
        check("sfx_busy", {31'd0, bus.sfx_busy}, {31'd0, e_busy});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        m_st = 0; m_fx = 0; m_el = 0; m_prev = 2'd0;
        reset = 1'b1;
        bus.mode = 2'd1; bus.music_tone = 32'd0;
        bus.req_drop = 1'b0; bus.req_clear = 1'b0; bus.req_over = 1'b0;
        cur_mode = 2'd1; cur_tone = 32'd440;

        // Reset then plain music pass-through.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_tone", bus.tone_out, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("s1_tone", bus.tone_out, 32'd440);

        // Full clear sequence, back to music on the 17th cycle.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("s2_step0", bus.tone_out, 32'd523);
        idle(15);
        check("s2_last", bus.tone_out, 32'd1047);
        idle(1);
        check("s2_back", bus.tone_out, 32'd440);
        check("s2_hold", {31'd0, bus.music_hold}, 32'd0);

        // Lower priority ignored, higher priority preempts.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("s3_ignored", bus.tone_out, 32'd784);
        idle(10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("s3_preempt", bus.tone_out, 32'd523);
        idle(20);

        // Simultaneous drop+over, silence, mode change releases.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("s4_over0", bus.tone_out, 32'd392);
        idle(31);
        idle(5);
        check("s4_silent", bus.tone_out, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        cur_mode = 2'd0;
        idle(1);
        check("s4_release", bus.tone_out, 32'd440);

        // Requests gated in start scene; mode change aborts an effect.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("s5_gated", {31'd0, bus.sfx_busy}, 32'd0);
        idle(3);
        cur_mode = 2'd1;
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        cur_mode = 2'd2;
        idle(1);
        check("s5_abort", {31'd0, bus.music_hold}, 32'd0);
        idle(3);

        // Reset mid game-over sequence.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(TD * 5);
        check("s6_step5", bus.tone_out, 32'd294);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("s6_rst", bus.tone_out, 32'd0);
        cur_tone = 32'd500;
        idle(1);
        check("s6_track", bus.tone_out, 32'd500);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) cur_tone = 32'($urandom_range(0, 2000));
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sfx_arbiter
`default_nettype wire
